// File: rtl/wb_arb_pkg.sv
// Shared types and sizing for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT0    = 2'd1,
    ST_GNT1    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int M_DISP = 0;
  localparam int M_CPU  = 1;

  localparam int TIMEOUT_DEF   = 255;
  localparam int MAX_BEATS_DEF = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Counters are sized for the top of each legal parameter range.
  localparam int WDT_W_MAX  = cnt_width(1023);
  localparam int BEAT_W_MAX = cnt_width(255);

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle between the display/CPU masters, the arbiter and the memory slave.
interface wb_mem_arbiter_if;

  logic [31:0] m0_adr_i, m1_adr_i;
  logic [31:0] m0_dat_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_cyc_i, m1_cyc_i;
  logic        m0_stb_i, m1_stb_i;
  logic        m0_we_i,  m1_we_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_err_o, m1_err_o;
  logic        m0_rty_o, m1_rty_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  // Arbiter side: slave to both masters, master to the memory.
  modport slave (
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
           m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
           s_dat_i, s_ack_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           m0_rty_o, m1_rty_o, s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o,
           s_we_o, gnt_o
  );

  // Environment side: the two requesters plus the memory responder.
  modport master (
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
           m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
           s_dat_i, s_ack_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           m0_rty_o, m1_rty_o, s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o,
           s_we_o, gnt_o
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Bus-hang watchdog: pulses o_expire on the TIMEOUT-th consecutive strobe cycle
// without an ack. An ack in that same cycle wins and clears the count.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam logic [WDT_W_MAX-1:0] TERM = WDT_W_MAX'(TIMEOUT - 1);

  logic [WDT_W_MAX-1:0] r_cnt;

  assign o_expire = i_stb & ~i_ack & (r_cnt == TERM);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_stb || i_ack || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + WDT_W_MAX'(1);
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master Wishbone arbiter with fairness retry and hang watchdog.
// state      | meaning
// ST_IDLE    | no owner; pick requester (tie goes to the master that is not last_owner)
// ST_GNT0    | display fetch (m0) owns the memory bus
// ST_GNT1    | CPU (m1) owns the memory bus
// ST_RELEASE | one-cycle bus turnaround with s_cyc_o low
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input logic            clk_100MHz,
  input logic            rst_n,
  wb_mem_arbiter_if.slave bus
);

  localparam logic [BEAT_W_MAX-1:0] BEAT_LIM = BEAT_W_MAX'(MAX_BEATS);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic                  r_last_owner;
  logic [BEAT_W_MAX-1:0] r_beats;

  logic w_own0, w_own1, w_own;
  logic w_req_stb, w_other_req;
  logic w_expire, w_retry, w_ack_fwd;

  assign w_own0 = (r_state == ST_GNT0);
  assign w_own1 = (r_state == ST_GNT1);
  assign w_own  = w_own0 | w_own1;

  // Owner's strobe before any suppression; the watchdog must see it even on a retry cycle.
  assign w_req_stb   = (w_own0 & bus.m0_cyc_i & bus.m0_stb_i) |
                       (w_own1 & bus.m1_cyc_i & bus.m1_stb_i);
  assign w_other_req = (w_own0 & bus.m1_cyc_i) | (w_own1 & bus.m0_cyc_i);

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .i_stb      (w_req_stb),
    .i_ack      (bus.s_ack_i),
    .o_expire   (w_expire)
  );

  assign w_retry   = w_req_stb & w_other_req & (r_beats == BEAT_LIM) & ~w_expire;
  assign w_ack_fwd = w_own & bus.s_ack_i & ~w_retry;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          w_state_nxt = (r_last_owner == 1'(M_DISP)) ? ST_GNT1 : ST_GNT0;
        end else if (bus.m0_cyc_i) begin
          w_state_nxt = ST_GNT0;
        end else if (bus.m1_cyc_i) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!bus.m0_cyc_i || w_expire || w_retry) w_state_nxt = ST_RELEASE;
      end
      ST_GNT1: begin
        if (!bus.m1_cyc_i || w_expire || w_retry) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'(M_CPU);
      r_beats      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        if (w_state_nxt == ST_GNT0) r_last_owner <= 1'(M_DISP);
        else if (w_state_nxt == ST_GNT1) r_last_owner <= 1'(M_CPU);
      end
      if (!w_own) begin
        r_beats <= '0;
      end else if (w_ack_fwd && (r_beats != BEAT_LIM)) begin
        r_beats <= r_beats + BEAT_W_MAX'(1);
      end
    end
  end

  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    if (w_own) begin
      bus.s_adr_o = w_own1 ? bus.m1_adr_i : bus.m0_adr_i;
      bus.s_dat_o = w_own1 ? bus.m1_dat_i : bus.m0_dat_i;
      bus.s_sel_o = w_own1 ? bus.m1_sel_i : bus.m0_sel_i;
      bus.s_we_o  = w_own1 ? bus.m1_we_i  : bus.m0_we_i;
      bus.s_cyc_o = (w_own1 ? bus.m1_cyc_i : bus.m0_cyc_i) & ~w_expire;
      bus.s_stb_o = w_req_stb & ~w_expire & ~w_retry;
    end
  end

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_ack_o = w_own0 & w_ack_fwd;
  assign bus.m1_ack_o = w_own1 & w_ack_fwd;
  assign bus.m0_err_o = w_own0 & w_expire;
  assign bus.m1_err_o = w_own1 & w_expire;
  assign bus.m0_rty_o = w_own0 & w_retry;
  assign bus.m1_rty_o = w_own1 & w_retry;
  assign bus.gnt_o    = {w_own1, w_own0};

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master Wishbone arbiter in front of the shared memory slave.
- Master 0 is the graphic card display fetch master; master 1 is the CPU data bus.
- Provides round-robin tenure grant, a fairness beat limit enforced through retry, and a bus-hang watchdog that terminates stalled cycles with an error.
- Sits between both masters and the memory controller; the display fetch master must never be starved by long CPU bursts, and the CPU must never be starved by the display.

Parameters:
- TIMEOUT, 255: cycles with s_stb_o high and no s_ack_i before the watchdog fires. Range 2..1023.
- MAX_BEATS, 16: acks per tenure before the owner is forced off, applied only while the other master requests. Range 1..255.

Ports:
- clk_100MHz  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_adr_i, m1_adr_i  in  32  master addresses.
- m0_dat_i, m1_dat_i  in  32  master write data.
- m0_sel_i, m1_sel_i  in  4  byte selects.
- m0_cyc_i, m1_cyc_i  in  1  cycle/request.
- m0_stb_i, m1_stb_i  in  1  strobe.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_dat_o, m1_dat_o  out  32  read data (s_dat_i broadcast to both).
- m0_ack_o, m1_ack_o  out  1  ack, routed to owner only.
- m0_err_o, m1_err_o  out  1  watchdog error, one-cycle pulse.
- m0_rty_o, m1_rty_o  out  1  fairness retry, one-cycle pulse.
- s_adr_o  out  32; s_dat_o  out  32; s_sel_o  out  4; s_cyc_o, s_stb_o, s_we_o  out  1  to memory slave.
- s_dat_i  in  32; s_ack_i  in  1  from memory slave.
- gnt_o  out  2  one-hot current owner (bit0 = m0), 0 when idle.

Behaviour:
- States: IDLE, GNT0, GNT1, RELEASE. All state and counters are registered; the slave-side mux is combinational from the registered state.
- Reset (rst_n low, asynchronous):
  - State is IDLE and gnt_o = 0.
  - last_owner = 1, so m0 wins the first tie.
  - Beat and watchdog counters are 0.
  - All ack/err/rty outputs are 0.
  - s_cyc_o, s_stb_o and s_we_o are 0.
  - Reset asserted mid-tenure drops s_cyc_o immediately.
- IDLE:
  - Only one mi_cyc_i high: go to GNTi.
  - Both high: grant the master that is not last_owner.
  - Grant is visible on the next edge, so the slave sees the first strobe one cycle after the request.
- GNTi:
  - s_adr/dat/sel/we/cyc/stb_o = master i signals.
  - mi_ack_o = s_ack_i. The non-owner's ack/err/rty are held at 0.
  - On entry, last_owner is set to i and the beat counter is cleared.
  - Beat counter increments on each s_ack_i and saturates at MAX_BEATS.
  - Owner drops mi_cyc_i: go to RELEASE.
- Fairness:
  - Applies when beat count = MAX_BEATS and the other master's cyc is high.
  - The owner's next strobe is not forwarded (s_stb_o = 0).
  - mi_rty_o pulses for one cycle with that strobe, then go to RELEASE.
  - The owner must drop cyc and re-request.
  - If the other master is not requesting, the owner continues unlimited.
- Watchdog:
  - Counts cycles with s_stb_o high and s_ack_i low; clears on ack or when stb is low.
  - At count = TIMEOUT: mi_err_o pulses one cycle, s_cyc_o/s_stb_o are forced low that cycle, then go to RELEASE.
- RELEASE:
  - Exactly one cycle with s_cyc_o = 0 (bus turnaround), then IDLE.
  - Any request pending in RELEASE is granted from IDLE on the following edge.
- Simultaneous events:
  - s_ack_i in the same cycle the watchdog reaches TIMEOUT: the ack wins, with no err and the counter cleared.
  - Fairness retry and timeout in the same cycle: err wins.
  - Owner drops cyc while the other master requests: RELEASE, then grant to the other master.
  - s_ack_i arriving while no grant is held (IDLE/RELEASE) is ignored.
- At most one of ack/err/rty is high per master per cycle.

Decomposition:
- Package wb_arb_pkg:
  - state encoding (IDLE, GNT0, GNT1, RELEASE);
  - master index constants M_DISP = 0, M_CPU = 1;
  - counter width localparams derived from TIMEOUT and MAX_BEATS.
- Sub-module wb_arb_watchdog:
  - inputs: clk_100MHz, rst_n, stb, ack, TIMEOUT;
  - output: one-cycle expire pulse;
  - reused later by other bus bridges.
- Grant FSM, beat counter and mux stay in wb_mem_arbiter.

Test Plan:
- Single master: m1 reads 0x40800000 with slave ack after 2 cycles.
  - Required: gnt_o = 2'b10 one cycle after cyc; m1_ack_o and data correct; m0_ack_o = 0.
  - After m1 drops cyc: one cycle of s_cyc_o = 0 (RELEASE), then gnt_o = 0.
- Tie at reset: m0 and m1 raise cyc in the same cycle.
  - Required: m0 granted first.
  - After m0 releases: RELEASE cycle, then m1 granted; the next tie goes to m0.
- Fairness, MAX_BEATS = 16: m1 bursts 40 single-cycle-ack beats while m0 requests.
  - Required: 16 acks to m1, then m1_rty_o on beat 17 with s_stb_o = 0.
  - Then RELEASE and a grant to m0.
- Fairness not triggered: same 40-beat m1 burst with m0 idle.
  - Required: all 40 acks, no rty.
- Watchdog, TIMEOUT = 8: slave never acks m0's strobe.
  - Required: m0_err_o pulses exactly on the 8th stalled cycle, s_cyc_o is low that cycle, then RELEASE.
- Corner: ack arrives exactly on cycle 8; rst_n pulsed low mid-burst.
  - Ack on cycle 8: ack delivered, no err.
  - Mid-burst reset: s_cyc_o drops asynchronously and gnt_o = 0 immediately.
